// File: rtl/fb_scanout_if.sv
// Plot bus from the game drawers into the framebuffer.
// One pixel per clk while plot is high; there is no stall path back to the drawer.
// The master drives x/y/colour/plot and the framebuffer sink is the slave.
interface fb_scanout_if;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    modport master (output x, y, colour, plot);
    modport slave  (input  x, y, colour, plot);
endinterface

// File: rtl/fb_scanout.sv
// Purpose: 160x120x3 framebuffer fed by the plot bus, scanned out as 640x480@60 VGA (4x4 replication), plus a vblank tick.
// Latency: plot writes land 1 clk after the strobe; VGA outputs trail the h/v counters by one pixel period (2 clk).
// Backpressure: none; plots are always accepted or dropped. Out-of-range plots bump drop_cnt. With FB_CLEAR_EN, plots are ignored while busy.
module fb_scanout #(
    parameter logic [2:0]  BG_COLOUR = 3'b000,
    parameter int unsigned DROP_W    = 8
) (
    input  logic              clk,
    input  logic              resetn,
    fb_scanout_if.slave       pbus,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic [2:0]        vga_rgb,
    output logic              pix_en,
    output logic              vblank_tick,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              busy
);
    localparam int unsigned FB_W     = 160;
    localparam int unsigned FB_DEPTH = 19200;

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        h_wrap;
    logic        v_wrap;
    logic        hs_raw;
    logic        vs_raw;
    logic        vis_raw;
    logic        hs_d;
    logic        vs_d;
    logic        vis_d;
    logic [14:0] rd_addr;
    logic [2:0]  rd_dat;
    logic [2:0]  mem [0:FB_DEPTH-1];

    logic        plot_in_range;
    logic        plot_ok;
    logic        plot_bad;
    logic [14:0] plot_addr;
    logic [14:0] clr_addr;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [2:0]  wr_dat;

    assign h_wrap = (h_cnt == 10'd799);
    assign v_wrap = (v_cnt == 10'd524);

    // 25 MHz pixel strobe: first clk after reset release drives it high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) pix_en <= 1'b0;
        else         pix_en <= ~pix_en;
    end

    // Raster position counters, advanced once per pixel.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h_cnt <= 10'd0;
                v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Marks the clk whose edge moves the raster from line 479 into vertical blank.
    assign vblank_tick = pix_en & h_wrap & (v_cnt == 10'd479);

    assign hs_raw  = !((h_cnt >= 10'd656) && (h_cnt <= 10'd751));
    assign vs_raw  = !((v_cnt == 10'd490) || (v_cnt == 10'd491));
    assign vis_raw = (h_cnt < 10'd640) && (v_cnt < 10'd480);

    // Each stored pixel covers a 4x4 block of screen pixels.
    assign rd_addr = 15'(v_cnt[9:2]) * 15'(FB_W) + 15'(h_cnt[9:2]);

    // Plot address decode and range check.
    assign plot_in_range = (pbus.x < 8'd160) && (pbus.y < 7'd120);
    assign plot_addr     = 15'(pbus.y) * 15'(FB_W) + 15'(pbus.x);
    assign plot_ok       = pbus.plot & plot_in_range & ~busy;
    assign plot_bad      = pbus.plot & ~plot_in_range & ~busy;

    // The clear sweep owns the write port while busy.
    assign wr_en   = busy | plot_ok;
    assign wr_addr = busy ? clr_addr : plot_addr;
    assign wr_dat  = busy ? BG_COLOUR : pbus.colour;

    // Framebuffer: read every clk, read-before-write on a same-address collision.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
        rd_dat <= mem[rd_addr];
    end

    // Sync/visible decode delayed alongside the memory read so they line up with rgb.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hs_d  <= 1'b1;
            vs_d  <= 1'b1;
            vis_d <= 1'b0;
        end else begin
            hs_d  <= hs_raw;
            vs_d  <= vs_raw;
            vis_d <= vis_raw;
        end
    end

    // VGA output register, updated only on pixel strobes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_rgb     <= 3'b000;
        end else if (pix_en) begin
            vga_hs      <= hs_d;
            vga_vs      <= vs_d;
            vga_blank_n <= vis_d;
            vga_rgb     <= vis_d ? rd_dat : 3'b000;
        end
    end

    // Saturating count of plots rejected for being off-screen.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                          drop_cnt <= '0;
        else if (plot_bad && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_W'(1);
    end

`ifdef FB_CLEAR_EN
    typedef enum logic [1:0] {CLR_IDLE, CLR_RUN, CLR_DONE} clr_state_t;

    clr_state_t  clr_state;
    clr_state_t  clr_state_nxt;
    logic [14:0] clr_addr_nxt;

    // Clear sweep state and address registers; reset restarts the sweep.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clr_state <= CLR_IDLE;
            clr_addr  <= 15'd0;
        end else begin
            clr_state <= clr_state_nxt;
            clr_addr  <= clr_addr_nxt;
        end
    end

    // Sweep sequencing: one address per clk from 0 to the last entry, then stay done.
    always_comb begin
        clr_state_nxt = clr_state;
        clr_addr_nxt  = clr_addr;
        busy          = 1'b0;
        case (clr_state)
            CLR_IDLE: clr_state_nxt = CLR_RUN;
            CLR_RUN: begin
                busy = 1'b1;
                if (clr_addr == 15'(FB_DEPTH - 1)) clr_state_nxt = CLR_DONE;
                else                                clr_addr_nxt  = clr_addr + 15'd1;
            end
            CLR_DONE: clr_state_nxt = CLR_DONE;
            default:  clr_state_nxt = CLR_IDLE;
        endcase
    end
`else
    assign busy     = 1'b0;
    assign clr_addr = 15'd0;
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: random plots against an array framebuffer model and a closed-form raster timebase.
`timescale 1ns/1ps
module tb_fb_scanout;
    localparam logic [2:0] BG    = 3'b001;
    localparam int         DEPTH = 19200;
`ifdef FB_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       vga_hs, vga_vs, vga_blank_n, pix_en, vblank_tick, busy;
    logic [2:0] vga_rgb;
    logic [7:0] drop_cnt;

    fb_scanout_if pbus();

    fb_scanout #(.BG_COLOUR(BG), .DROP_W(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pbus       (pbus),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vga_blank_n(vga_blank_n),
        .vga_rgb    (vga_rgb),
        .pix_en     (pix_en),
        .vblank_tick(vblank_tick),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Model state: g counts every clk edge, g_rel is g at the last reset release.
    int       g = 0;
    int       g_rel = 0;
    bit       in_rst = 1'b1;
    int       drop_m = 0;
    bit [2:0] m_cur [DEPTH];
    bit [2:0] m_old [DEPTH];
    bit       kn_cur [DEPTH];
    bit       kn_old [DEPTH];
    int       m_we [DEPTH];

    function automatic void mwrite(int a, bit [2:0] c);
        m_old[a]  = m_cur[a];
        kn_old[a] = kn_cur[a];
        m_cur[a]  = c;
        kn_cur[a] = 1'b1;
        m_we[a]   = g;
    endfunction

    // Advance one clk edge, apply what the design should have done at it, then move off the edge.
    task automatic tick();
        int  k;
        bit  bsy;
        @(posedge clk);
        g++;
        k   = g - g_rel;
        bsy = CLR && (k >= 2) && (k <= DEPTH + 1);
        if (!in_rst) begin
            if (bsy) mwrite(k - 2, BG);
            else if (pbus.plot === 1'b1) begin
                if (pbus.x < 8'd160 && pbus.y < 7'd120)
                    mwrite(int'(pbus.y) * 160 + int'(pbus.x), pbus.colour);
                else if (drop_m < 255)
                    drop_m++;
            end
        end
        #5;
    endtask

    // Expected outputs for the current instant, from raster arithmetic and the memory model.
    task automatic model_out(output bit e_hs, output bit e_vs, output bit e_bn, output bit e_pe,
                             output bit e_vt, output bit e_bz, output bit [2:0] e_rgb, output bit e_kn);
        int k, p, h, v, a, r;
        e_hs = 1; e_vs = 1; e_bn = 0; e_pe = 0; e_vt = 0; e_bz = 0; e_rgb = 3'b000; e_kn = 1;
        if (in_rst) return;
        k    = g - g_rel;
        e_pe = (k % 2) == 1;
        e_bz = CLR && (k >= 1) && (k <= DEPTH);
        e_vt = e_pe && (((k / 2) % 420000) == 479 * 800 + 799);
        if (k < 2) return;
        p    = k / 2 - 1;
        h    = p % 800;
        v    = (p / 800) % 525;
        e_hs = !(h >= 656 && h <= 751);
        e_vs = !(v == 490 || v == 491);
        e_bn = (h < 640) && (v < 480);
        if (e_bn) begin
            a = (v / 4) * 160 + h / 4;
            r = g_rel + 2 * p + 1;
            if (m_we[a] >= 0 && m_we[a] < r) begin e_rgb = m_cur[a]; e_kn = kn_cur[a]; end
            else                             begin e_rgb = m_old[a]; e_kn = kn_old[a]; end
        end
    endtask

    task automatic release_reset();
        resetn = 1'b1;
        in_rst = 1'b0;
        g_rel  = g;
    endtask

    task automatic test_reset();
        pbus.plot = 0; pbus.x = 0; pbus.y = 0; pbus.colour = 0;
        resetn = 1'b0; in_rst = 1'b1; drop_m = 0;
        repeat (3) tick();
        vecs++; if (vga_hs !== 1'b1)      begin errs++; $display("FAIL rst_hs got %b want 1", vga_hs); end
        vecs++; if (vga_vs !== 1'b1)      begin errs++; $display("FAIL rst_vs got %b want 1", vga_vs); end
        vecs++; if (vga_blank_n !== 1'b0) begin errs++; $display("FAIL rst_blank_n got %b want 0", vga_blank_n); end
        vecs++; if (vga_rgb !== 3'b000)   begin errs++; $display("FAIL rst_rgb got %b want 000", vga_rgb); end
        vecs++; if (pix_en !== 1'b0)      begin errs++; $display("FAIL rst_pix_en got %b want 0", pix_en); end
        vecs++; if (vblank_tick !== 1'b0) begin errs++; $display("FAIL rst_vblank got %b want 0", vblank_tick); end
        vecs++; if (drop_cnt !== 8'd0)    begin errs++; $display("FAIL rst_drop got %0d want 0", drop_cnt); end
        vecs++; if (busy !== 1'b0)        begin errs++; $display("FAIL rst_busy got %b want 0", busy); end
        release_reset();
    endtask

    task automatic test_timing();
        bit e_hs, e_vs, e_bn, e_pe, e_vt, e_bz, e_kn;
        bit [2:0] e_rgb;
        logic prev_hs;
        int fall1, fall2, rise1, k;
        fall1 = -1; fall2 = -1; rise1 = -1;
        prev_hs = vga_hs;
        for (int n = 0; n < 3000; n++) begin
            tick();
            model_out(e_hs, e_vs, e_bn, e_pe, e_vt, e_bz, e_rgb, e_kn);
            k = g - g_rel;
            vecs++; if (vga_hs !== e_hs)      begin errs++; $display("FAIL tim_hs k=%0d got %b want %b", k, vga_hs, e_hs); end
            vecs++; if (vga_vs !== e_vs)      begin errs++; $display("FAIL tim_vs k=%0d got %b want %b", k, vga_vs, e_vs); end
            vecs++; if (vga_blank_n !== e_bn) begin errs++; $display("FAIL tim_blank k=%0d got %b want %b", k, vga_blank_n, e_bn); end
            vecs++; if (pix_en !== e_pe)      begin errs++; $display("FAIL tim_pix_en k=%0d got %b want %b", k, pix_en, e_pe); end
            vecs++; if (vblank_tick !== e_vt) begin errs++; $display("FAIL tim_vblank k=%0d got %b want %b", k, vblank_tick, e_vt); end
            vecs++; if (busy !== e_bz)        begin errs++; $display("FAIL tim_busy k=%0d got %b want %b", k, busy, e_bz); end
            if (prev_hs === 1'b1 && vga_hs === 1'b0) begin
                if (fall1 < 0) fall1 = k; else if (fall2 < 0) fall2 = k;
            end
            if (prev_hs === 1'b0 && vga_hs === 1'b1 && rise1 < 0) rise1 = k;
            prev_hs = vga_hs;
        end
        vecs++; if (fall1 != 1314)         begin errs++; $display("FAIL hs_first_fall got clk %0d want 1314", fall1); end
        vecs++; if (rise1 - fall1 != 192)  begin errs++; $display("FAIL hs_low_len got %0d want 192", rise1 - fall1); end
        vecs++; if (fall2 - fall1 != 1600) begin errs++; $display("FAIL line_period got %0d want 1600", fall2 - fall1); end
    endtask

    task automatic test_plot();
        for (int y = 0; y < 6; y++) begin
            for (int x = 0; x < 160; x++) begin
                pbus.plot = 1; pbus.x = 8'(x); pbus.y = 7'(y);
                pbus.colour = (x == 0 && y == 0) ? 3'b100 : 3'($urandom_range(0, 7));
                tick();
            end
        end
        pbus.x = 8'd159; pbus.y = 7'd119; pbus.colour = 3'b011;
        tick();
        pbus.plot = 0;
        tick();
        vecs++; if (drop_cnt !== 8'(drop_m)) begin errs++; $display("FAIL plot_drop got %0d want %0d", drop_cnt, drop_m); end
    endtask

    task automatic test_drop();
        for (int n = 0; n < 300; n++) begin
            pbus.plot = 1; pbus.colour = 3'($urandom_range(0, 7));
            if (n % 2 == 0) begin pbus.x = 8'($urandom_range(160, 255)); pbus.y = 7'($urandom_range(0, 5)); end
            else            begin pbus.x = 8'($urandom_range(0, 159));   pbus.y = 7'($urandom_range(120, 127)); end
            tick();
            vecs++; if (drop_cnt !== 8'(drop_m)) begin errs++; $display("FAIL drop n=%0d got %0d want %0d", n, drop_cnt, drop_m); end
        end
        pbus.plot = 0;
        tick();
    endtask

    task automatic test_reset_midline();
        bit found;
        found = 0;
        for (int n = 0; n < 2000 && !found; n++) begin
            tick();
            if (((g - g_rel) / 2) % 800 == 300) found = 1;
        end
        vecs++; if (!found) begin errs++; $display("FAIL midline_wait got none want h=300"); end
        resetn = 1'b0; in_rst = 1'b1; drop_m = 0;
        #1;
        vecs++; if (vga_hs !== 1'b1)      begin errs++; $display("FAIL mid_hs got %b want 1", vga_hs); end
        vecs++; if (vga_vs !== 1'b1)      begin errs++; $display("FAIL mid_vs got %b want 1", vga_vs); end
        vecs++; if (vga_blank_n !== 1'b0) begin errs++; $display("FAIL mid_blank got %b want 0", vga_blank_n); end
        vecs++; if (vga_rgb !== 3'b000)   begin errs++; $display("FAIL mid_rgb got %b want 000", vga_rgb); end
        vecs++; if (pix_en !== 1'b0)      begin errs++; $display("FAIL mid_pix_en got %b want 0", pix_en); end
        vecs++; if (drop_cnt !== 8'd0)    begin errs++; $display("FAIL mid_drop got %0d want 0", drop_cnt); end
        vecs++; if (busy !== 1'b0)        begin errs++; $display("FAIL mid_busy got %b want 0", busy); end
        repeat (2) tick();
        release_reset();
    endtask

    task automatic test_scan_collision();
        bit e_hs, e_vs, e_bn, e_pe, e_vt, e_bz, e_kn;
        bit [2:0] e_rgb, old_c;
        int bx, by, pc, k, a;
        by = $urandom_range(1, 5);
        bx = $urandom_range(0, 39);
        pc = 4 * by * 800 + 4 * bx;
        a  = by * 160 + bx;
        old_c = m_cur[a];
        for (int n = 0; n < 24 * 1600 + 4; n++) begin
            tick();
            k = g - g_rel;
            model_out(e_hs, e_vs, e_bn, e_pe, e_vt, e_bz, e_rgb, e_kn);
            vecs++; if (vga_hs !== e_hs)      begin errs++; $display("FAIL scan_hs k=%0d got %b want %b", k, vga_hs, e_hs); end
            vecs++; if (vga_blank_n !== e_bn) begin errs++; $display("FAIL scan_blank k=%0d got %b want %b", k, vga_blank_n, e_bn); end
            if (e_kn) begin
                vecs++; if (vga_rgb !== e_rgb) begin errs++; $display("FAIL scan_rgb k=%0d got %b want %b", k, vga_rgb, e_rgb); end
            end
            if (k == 2 * pc + 2 && kn_old[a]) begin
                vecs++; if (vga_rgb !== old_c) begin errs++; $display("FAIL collide_old k=%0d got %b want %b", k, vga_rgb, old_c); end
            end
            if (k == 2 * pc) begin
                pbus.plot = 1; pbus.x = 8'(bx); pbus.y = 7'(by); pbus.colour = ~old_c;
            end else begin
                pbus.plot = 0;
            end
        end
        pbus.plot = 0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_we[i] = -1; kn_cur[i] = 0; kn_old[i] = 0; m_cur[i] = 0; m_old[i] = 0;
        end
        test_reset();
        test_timing();
        test_plot();
        test_drop();
        test_reset_midline();
        test_scan_collision();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
